// File: rtl/l1dir_pkg.sv
// Shared definitions for the L1 shadow directory front-end sequencer:
// op-word bit map, FSM encoding and the inval-vector valid-bit positions.
package l1dir_pkg;

  localparam int OP_LOAD       = 0;
  localparam int OP_IFILL      = 1;
  localparam int OP_STORE      = 2;
  localparam int OP_CAS        = 3;
  localparam int OP_SWAP       = 4;
  localparam int OP_STRLOAD    = 5;
  localparam int OP_STRSTORE   = 6;
  localparam int OP_CACHEABLE  = 7;
  localparam int OP_PREFETCH   = 8;
  localparam int OP_INVALIDATE = 9;
  localparam int OP_BLOCKSTORE = 10;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    LOOK = 2'd2,
    RESP = 2'd3
  } state_t;

  // Valid bits inside a 112-bit invalidation vector:
  // [1:0], [5:4], [32], [35], [57:56], [61:60], [88], [91]
  localparam logic [111:0] INV_VALID_MASK =
      (112'd3 << 0)  | (112'd3 << 4)  | (112'd1 << 32) | (112'd1 << 35) |
      (112'd3 << 56) | (112'd3 << 60) | (112'd1 << 88) | (112'd1 << 91);

  function automatic logic inv_any(input logic [111:0] v);
    return |(v & INV_VALID_MASK);
  endfunction

endpackage

// File: rtl/l1dir_rr_arb2.sv
// Two-way round-robin arbiter; owns the priority pointer, which moves past
// the granted requester whenever advance is asserted.
module l1dir_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic ptr;

  always_comb begin
    gnt_id = req[ptr] ? ptr : ~ptr;
    gnt    = 2'b00;
    if (|req) gnt = gnt_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset)        ptr <= 1'b0;
    else if (advance) ptr <= ~gnt_id;
  end

endmodule

// File: rtl/l1dir_sched.sv
// Round-robin sequencer sharing one L1 directory between cpu0/cpu1.
// Optional DIRSCHED_STATS_EN adds saturating lookup/back-pressure counters.
module l1dir_sched
  import l1dir_pkg::*;
#(
  parameter int LOOKUP_LAT = 2,
  parameter int OP_W       = 11
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [OP_W-1:0] req_op0,
  input  logic [OP_W-1:0] req_op1,
  input  logic [39:0]     req_addr0,
  input  logic [39:0]     req_addr1,
  input  logic [1:0]      req_way0,
  input  logic [1:0]      req_way1,
  input  logic            dir_ready,
  output logic            dir_strobe,
  output logic            dir_cpu,
  output logic [OP_W-1:0] dir_op,
  output logic [39:0]     dir_addr,
  output logic [1:0]      dir_way,
  input  logic [111:0]    dir_inval0,
  input  logic [111:0]    dir_inval1,
  input  logic [1:0]      dir_wayval0,
  input  logic [1:0]      dir_wayval1,
  input  logic [1:0]      dir_ocache,
  input  logic [1:0]      dir_ocpu,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_cpu,
  output logic [111:0]    res_inval0,
  output logic [111:0]    res_inval1,
  output logic [1:0]      res_wayval0,
  output logic [1:0]      res_wayval1,
  output logic [1:0]      res_ocache,
  output logic [1:0]      res_ocpu,
  output logic            res_need_inv
`ifdef DIRSCHED_STATS_EN
  ,
  output logic [15:0]     stat_lk0,
  output logic [15:0]     stat_lk1,
  output logic [15:0]     stat_bp
`endif
);

  state_t          state, state_nx;
  logic [2:0]      cnt;
  logic            grant, capture, gnt_id;
  logic [1:0]      gnt;
  logic            lat_cpu;
  logic [OP_W-1:0] lat_op;
  logic [39:0]     lat_addr;
  logic [1:0]      lat_way;

  assign grant   = (state == IDLE) && dir_ready && (|req_valid);
  assign capture = (state == LOOK) && (cnt == 3'(LOOKUP_LAT - 1));

  l1dir_rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (grant),
    .gnt     (gnt),
    .gnt_id  (gnt_id)
  );

  // Grant cycle drives straight from the requester; afterwards the latched copy holds.
  assign dir_strobe = grant;
  assign req_ready  = grant ? gnt : 2'b00;
  assign dir_cpu    = grant ? gnt_id : lat_cpu;
  assign dir_op     = grant ? (gnt_id ? req_op1   : req_op0)   : lat_op;
  assign dir_addr   = grant ? (gnt_id ? req_addr1 : req_addr0) : lat_addr;
  assign dir_way    = grant ? (gnt_id ? req_way1  : req_way0)  : lat_way;

  assign res_need_inv = inv_any(res_inval0) | inv_any(res_inval1);

  always_comb begin
    state_nx = state;
    case (state)
      INIT: if (dir_ready) state_nx = IDLE;
      IDLE: if (!dir_ready) state_nx = INIT;
            else if (|req_valid) state_nx = LOOK;
      LOOK: if (capture) state_nx = RESP;
      RESP: if (res_valid && res_ready) state_nx = dir_ready ? IDLE : INIT;
      default: state_nx = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= INIT;
      cnt         <= 3'd0;
      lat_cpu     <= 1'b0;
      lat_op      <= '0;
      lat_addr    <= '0;
      lat_way     <= '0;
      res_valid   <= 1'b0;
      res_cpu     <= 1'b0;
      res_inval0  <= '0;
      res_inval1  <= '0;
      res_wayval0 <= '0;
      res_wayval1 <= '0;
      res_ocache  <= '0;
      res_ocpu    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= (state == LOOK) ? cnt + 3'd1 : 3'd0;
      if (grant) begin
        lat_cpu  <= dir_cpu;
        lat_op   <= dir_op;
        lat_addr <= dir_addr;
        lat_way  <= dir_way;
      end
      if (capture) begin
        res_valid   <= 1'b1;
        res_cpu     <= lat_cpu;
        res_inval0  <= dir_inval0;
        res_inval1  <= dir_inval1;
        res_wayval0 <= dir_wayval0;
        res_wayval1 <= dir_wayval1;
        res_ocache  <= dir_ocache;
        res_ocpu    <= dir_ocpu;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

`ifdef DIRSCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_lk0 <= '0;
      stat_lk1 <= '0;
      stat_bp  <= '0;
    end else begin
      if (req_ready[0] && stat_lk0 != 16'hFFFF) stat_lk0 <= stat_lk0 + 16'd1;
      if (req_ready[1] && stat_lk1 != 16'hFFFF) stat_lk1 <= stat_lk1 + 16'd1;
      if (state == RESP && !res_ready && stat_bp != 16'hFFFF) stat_bp <= stat_bp + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1dir_sched.sv
// Bench for l1dir_sched: table-driven transactions, hand-written corner
// sequences, and a randomized run against a cycle-level reference model.
module tb_l1dir_sched;
  import l1dir_pkg::*;

  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   req_valid, req_ready;
  logic [10:0]  req_op0, req_op1, dir_op;
  logic [39:0]  req_addr0, req_addr1, dir_addr;
  logic [1:0]   req_way0, req_way1, dir_way;
  logic         dir_ready, dir_strobe, dir_cpu;
  logic [111:0] dir_inval0, dir_inval1, res_inval0, res_inval1;
  logic [1:0]   dir_wayval0, dir_wayval1, dir_ocache, dir_ocpu;
  logic         res_valid, res_ready, res_cpu, res_need_inv;
  logic [1:0]   res_wayval0, res_wayval1, res_ocache, res_ocpu;
`ifdef DIRSCHED_STATS_EN
  logic [15:0]  stat_lk0, stat_lk1, stat_bp;
`endif

  always #5 clk = ~clk;

  l1dir_sched #(.LOOKUP_LAT(LAT), .OP_W(11)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_way0(req_way0), .req_way1(req_way1),
    .dir_ready(dir_ready), .dir_strobe(dir_strobe), .dir_cpu(dir_cpu),
    .dir_op(dir_op), .dir_addr(dir_addr), .dir_way(dir_way),
    .dir_inval0(dir_inval0), .dir_inval1(dir_inval1),
    .dir_wayval0(dir_wayval0), .dir_wayval1(dir_wayval1),
    .dir_ocache(dir_ocache), .dir_ocpu(dir_ocpu),
    .res_valid(res_valid), .res_ready(res_ready), .res_cpu(res_cpu),
    .res_inval0(res_inval0), .res_inval1(res_inval1),
    .res_wayval0(res_wayval0), .res_wayval1(res_wayval1),
    .res_ocache(res_ocache), .res_ocpu(res_ocpu),
    .res_need_inv(res_need_inv)
`ifdef DIRSCHED_STATS_EN
    , .stat_lk0(stat_lk0), .stat_lk1(stat_lk1), .stat_bp(stat_bp)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int inv_pos [12] = '{0, 1, 4, 5, 32, 35, 56, 57, 60, 61, 88, 91};

  typedef struct {
    logic         cpu;
    logic [39:0]  addr;
    logic [10:0]  op;
    logic [111:0] inv0;
    logic [111:0] inv1;
    logic         need;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic need_of(input logic [111:0] a, input logic [111:0] b);
    logic r = 1'b0;
    foreach (inv_pos[i]) r = r | a[inv_pos[i]] | b[inv_pos[i]];
    return r;
  endfunction

  function automatic vec_t mk(input logic cpu, input logic [39:0] addr, input int opbit,
                              input int b0, input int b1, input logic need);
    vec_t v;
    v.cpu  = cpu;
    v.addr = addr;
    v.op   = 11'd1 << opbit;
    v.inv0 = (b0 >= 0) ? (112'd1 << b0) : 112'd0;
    v.inv1 = (b1 >= 0) ? (112'd1 << b1) : 112'd0;
    v.need = need;
    return v;
  endfunction

  // Returns at the negedge where the watched output is seen high, or after budget cycles.
  task automatic wait_for(input bit which, input int budget, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    forever begin
      @(negedge clk);
      if (which ? res_valid : dir_strobe) begin ok = 1'b1; return; end
      n++;
      if (n >= budget) return;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; req_valid = 2'b00; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int cycles);
    @(posedge clk); #1;
    req_valid = 2'b00; res_ready = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 res_ready = 1'b0;
  endtask

  task automatic txn(input vec_t v, input string nm);
    int n;
    bit ok;
    @(posedge clk); #1;
    req_valid = v.cpu ? 2'b10 : 2'b01;
    if (v.cpu) begin req_addr1 = v.addr; req_op1 = v.op; req_way1 = 2'd2; end
    else       begin req_addr0 = v.addr; req_op0 = v.op; req_way0 = 2'd2; end
    dir_inval0 = v.inv0; dir_inval1 = v.inv1;
    dir_wayval0 = 2'b01; dir_wayval1 = 2'b10; dir_ocache = 2'b11; dir_ocpu = 2'b10;
    res_ready = 1'b0;
    wait_for(1'b0, 20, n, ok);
    chk({nm, "_strobe"}, ok, 1);
    chk({nm, "_cpu"}, dir_cpu, v.cpu);
    chk({nm, "_addr"}, dir_addr, v.addr);
    chk({nm, "_op"}, dir_op, v.op);
    chk({nm, "_way"}, dir_way, 2'd2);
    chk({nm, "_rdy"}, req_ready, v.cpu ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    req_valid = 2'b00;
    wait_for(1'b1, 20, n, ok);
    // Result register loads LAT edges after the strobe edge, visible one cycle later.
    chk({nm, "_resv"}, ok, 1);
    chk({nm, "_reslat"}, n, LAT);
    chk({nm, "_rescpu"}, res_cpu, v.cpu);
    chk({nm, "_inv0"}, res_inval0, v.inv0);
    chk({nm, "_inv1"}, res_inval1, v.inv1);
    chk({nm, "_wv"}, {res_wayval1, res_wayval0, res_ocache, res_ocpu}, 8'b10_01_11_10);
    chk({nm, "_need"}, res_need_inv, v.need);
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_done"}, res_valid, 0);
  endtask

  initial begin
    int n;
    bit ok;
    int scyc [4];
    logic scpu [4];
    int got;
    logic [111:0] s_inv0;
    logic [1:0]   s_ocpu;
    logic         s_cpu;
`ifdef DIRSCHED_STATS_EN
    logic [15:0]  bp0;
`endif

    reset = 1'b1; req_valid = 2'b00; dir_ready = 1'b0; res_ready = 1'b0;
    req_op0 = '0; req_op1 = '0; req_addr0 = '0; req_addr1 = '0; req_way0 = '0; req_way1 = '0;
    dir_inval0 = '0; dir_inval1 = '0; dir_wayval0 = '0; dir_wayval1 = '0;
    dir_ocache = '0; dir_ocpu = '0;

    tbl[0] = mk(1'b1, 40'h12_3456_7890, OP_STORE,      -1,  -1, 1'b0);
    tbl[1] = mk(1'b0, 40'h00_0000_0040, OP_LOAD,       57,  -1, 1'b1);
    tbl[2] = mk(1'b1, 40'hFF_FFFF_FFC0, OP_IFILL,      -1,  -1, 1'b0);
    tbl[3] = mk(1'b0, 40'h80_0000_0000, OP_CAS,        -1,  91, 1'b1);
    tbl[4] = mk(1'b1, 40'h0A_5A5A_5A5A, OP_SWAP,        2,  -1, 1'b0);
    tbl[5] = mk(1'b0, 40'h55_AAAA_5500, OP_LOAD,       -1,  33, 1'b0);
    tbl[6] = mk(1'b1, 40'h01_0203_0405, OP_STRLOAD,    88,  -1, 1'b1);
    tbl[7] = mk(1'b0, 40'h33_3333_3330, OP_BLOCKSTORE, 110, 111, 1'b0);
    tbl[8] = mk(1'b0, 40'h44_0000_1000, OP_PREFETCH,    0,  -1, 1'b1);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_strobe", dir_strobe, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_resv", res_valid, 0);
    chk("rst_dir", {dir_cpu, dir_addr, dir_op, dir_way}, 0);
    chk("rst_res", {res_cpu, res_inval0, res_need_inv}, 0);
    @(posedge clk); #1 reset = 1'b0;

    // No grant while the directory is initialising
    req_valid = 2'b01; req_addr0 = 40'h00_0000_1111; req_op0 = 11'd1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dir_strobe) got++;
      @(posedge clk); #1;
    end
    chk("init_nostrobe", got, 0);
    dir_ready = 1'b1;
    wait_for(1'b0, 5, n, ok);
    chk("init_strobe_soon", ok && n <= 2, 1);
    chk("init_cpu", dir_cpu, 0);
    drain(8);

    foreach (tbl[i]) txn(tbl[i], $sformatf("tbl%0d", i));

    // Both requesting, consumer always ready: 0,1,0,1 at LAT+2 spacing
    do_reset();
    req_valid = 2'b11; res_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 4; c++) begin
      @(negedge clk);
      if (dir_strobe) begin scyc[got] = c; scpu[got] = dir_cpu; got++; end
      @(posedge clk); #1;
    end
    chk("alt_count", got, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("alt_cpu%0d", k), scpu[k], k[0]);
    for (int k = 1; k < 4; k++) chk($sformatf("alt_gap%0d", k), scyc[k] - scyc[k-1], LAT + 2);
    drain(8);

    // Back-pressure: result held, no new strobe, next strobe one cycle after handshake
    @(posedge clk); #1;
    req_valid = 2'b01; req_addr0 = 40'h0B_0000_0000; res_ready = 1'b0;
    dir_inval0 = 112'd1 << 5; dir_ocpu = 2'b01;
    wait_for(1'b0, 20, n, ok);
    chk("bp_strobe", ok, 1);
    @(posedge clk); #1;
    req_valid = 2'b10; req_addr1 = 40'h0C_0000_0000;
    wait_for(1'b1, 20, n, ok);
    chk("bp_resv", ok, 1);
    s_inv0 = res_inval0; s_ocpu = res_ocpu; s_cpu = res_cpu;
    chk("bp_cap", {s_cpu, s_ocpu, res_need_inv}, {1'b0, 2'b01, 1'b1});
`ifdef DIRSCHED_STATS_EN
    bp0 = stat_bp;
`endif
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin @(posedge clk); #1 dir_inval0 = '1; dir_ocpu = 2'b10; @(negedge clk); end
      chk("bp_hold_v", res_valid, 1);
      chk("bp_hold_d", {res_cpu, res_inval0, res_ocpu}, {s_cpu, s_inv0, s_ocpu});
      chk("bp_nostrobe", dir_strobe, 0);
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_nostrobe", dir_strobe, 0);
`ifdef DIRSCHED_STATS_EN
    chk("bp_stat", stat_bp - bp0, 16'd10);
`endif
    @(posedge clk); #1 res_ready = 1'b0;
    @(negedge clk);
    chk("bp_next_strobe", {dir_strobe, dir_cpu, res_valid}, 3'b110);
    drain(8);

    // Reset one cycle after a strobe discards the lookup and resets the pointer
    @(posedge clk); #1;
    req_valid = 2'b01; res_ready = 1'b0;
    wait_for(1'b0, 20, n, ok);
    chk("rmid_strobe", ok, 1);
    @(posedge clk); #1 reset = 1'b1; req_valid = 2'b11;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rmid_init", {dir_strobe, res_valid}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rmid_ptr0", {dir_strobe, dir_cpu, res_valid}, 3'b100);
    drain(8);

    // Randomized run against the reference model
    begin
      bit          pend [2], acc [2];
      logic [39:0] raddr [2];
      logic [1:0]  rway [2];
      logic [10:0] rop [2];
      bit          m_free, m_rv, m_cpu, ptr, exp_s;
      int          cap_at, g;
      logic [111:0] e_inv0, e_inv1;
      logic [1:0]   e_ocpu;
      do_reset();
      repeat (2) @(posedge clk);
      #1;
      m_free = 1; m_rv = 0; ptr = 0; cap_at = -1; m_cpu = 0;
      e_inv0 = '0; e_inv1 = '0; e_ocpu = '0;
      foreach (pend[k]) begin pend[k] = 0; acc[k] = 0; raddr[k] = '0; rway[k] = '0; rop[k] = '0; end
      for (int c = 0; c < 800; c++) begin
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
          if (acc[k]) pend[k] = 0;
          acc[k] = 0;
          if (!pend[k] && $urandom_range(2) == 0) begin
            pend[k] = 1;
            raddr[k] = {8'($urandom), $urandom};
            rway[k] = 2'($urandom);
            rop[k] = 11'($urandom);
          end
        end
        req_valid = {pend[1], pend[0]};
        req_addr0 = raddr[0]; req_addr1 = raddr[1];
        req_way0 = rway[0]; req_way1 = rway[1];
        req_op0 = rop[0]; req_op1 = rop[1];
        dir_inval0 = {16'($urandom), $urandom, $urandom, $urandom};
        dir_inval1 = {16'($urandom), $urandom, $urandom, $urandom} & {112{$urandom_range(1) == 1}};
        dir_ocpu = 2'($urandom);
        res_ready = ($urandom_range(2) != 0);
        @(negedge clk);
        exp_s = m_free && (pend[0] || pend[1]);
        chk("rnd_strobe", dir_strobe, exp_s);
        if (exp_s) begin
          g = pend[ptr] ? int'(ptr) : 1 - int'(ptr);
          chk("rnd_cpu", dir_cpu, g[0]);
          chk("rnd_addr", dir_addr, raddr[g]);
          chk("rnd_way_op", {dir_way, dir_op}, {rway[g], rop[g]});
          chk("rnd_rdy", req_ready, 2'b01 << g);
          acc[g] = 1; ptr = ~g[0]; m_free = 0; m_cpu = g[0]; cap_at = c + LAT;
        end else begin
          chk("rnd_rdy0", req_ready, 0);
        end
        chk("rnd_resv", res_valid, m_rv);
        if (m_rv) begin
          chk("rnd_rescpu", res_cpu, m_cpu);
          chk("rnd_inv", {res_inval0, res_ocpu}, {e_inv0, e_ocpu});
          chk("rnd_inv1", res_inval1, e_inv1);
          chk("rnd_need", res_need_inv, need_of(e_inv0, e_inv1));
          if (res_ready) begin m_rv = 0; m_free = 1; end
        end
        if (c == cap_at) begin
          e_inv0 = dir_inval0; e_inv1 = dir_inval1; e_ocpu = dir_ocpu; m_rv = 1;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
